// File: rtl/axis_slice_chain_if.sv
// ============================================================================
// Module   : axis_if
// Brief    : AXI Stream handshake bundle (tvalid/tready/tdata) with manager
//            and subordinate modports.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axis_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_slice_chain.sv
// ============================================================================
// Module   : axis_slice_chain
// Brief    : Cascade of STAGES AXI Stream register slices (forward or skid)
//            with chain-wide flush, occupancy counter and empty flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_slice_chain #(
    parameter int STAGES = 1,
    parameter int SKID   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    axis_if.m                                     axis_mif,
    axis_if.s                                     axis_sif,
    input  logic                                  invalidate,
    output logic [$clog2(STAGES*(SKID+1)+1)-1:0]  occupancy,
    output logic                                  empty
);

    localparam int c_cap         = STAGES * (SKID + 1);
    localparam int c_occ_w       = $clog2(c_cap + 1);
    localparam int c_tdata_width = $bits(axis_mif.tdata);

    if (STAGES < 1) begin : g_chk_stages
        $fatal(1, "axis_slice_chain: STAGES must be >= 1");
    end
    if (c_tdata_width <= 0) begin : g_chk_width_pos
        $fatal(1, "axis_slice_chain: TDATA_WIDTH must be > 0");
    end
    if ($bits(axis_sif.tdata) != c_tdata_width) begin : g_chk_width_eq
        $fatal(1, "axis_slice_chain: axis_sif/axis_mif TDATA_WIDTH differ");
    end

    // Each stage owns its own link signals so the ready chain never loops
    // back through a shared vector.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                     w_up_valid;
        logic [c_tdata_width-1:0] w_up_data;
        logic                     w_up_ready;
        logic                     w_dn_valid;
        logic [c_tdata_width-1:0] w_dn_data;
        logic                     w_dn_ready;

        if (k == 0) begin : g_first
            assign w_up_valid = axis_sif.tvalid;
            assign w_up_data  = axis_sif.tdata;
        end else begin : g_next
            assign w_up_valid = g_stage[k-1].w_dn_valid;
            assign w_up_data  = g_stage[k-1].w_dn_data;
        end

        if (k == STAGES - 1) begin : g_last
            assign w_dn_ready = axis_mif.tready;
        end else begin : g_inner
            assign w_dn_ready = g_stage[k+1].w_up_ready;
        end

        if (SKID == 0) begin : g_fwd
            logic                     r_valid;
            logic [c_tdata_width-1:0] r_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (invalidate) begin
                    r_valid <= 1'b0;
                end else if (w_up_ready) begin
                    r_valid <= w_up_valid;
                    if (w_up_valid) begin
                        r_data <= w_up_data;
                    end
                end
            end

            assign w_up_ready = !r_valid || w_dn_ready;
            assign w_dn_valid = r_valid;
            assign w_dn_data  = r_data;
        end else begin : g_skid
            logic                     r_m_valid;
            logic [c_tdata_width-1:0] r_m_data;
            logic                     r_s_valid;
            logic [c_tdata_width-1:0] r_s_data;
            logic                     w_in_fire;
            logic                     w_out_fire;

            assign w_in_fire  = w_up_valid && !r_s_valid;
            assign w_out_fire = r_m_valid && w_dn_ready;

            // Upstream ready comes only from the skid flag, so a full skid
            // entry blocks input even in a cycle where the output drains.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                    r_s_valid <= 1'b0;
                    r_s_data  <= '0;
                end else if (invalidate) begin
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                end else if (!r_m_valid || w_out_fire) begin
                    if (r_s_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_s_data;
                        r_s_valid <= 1'b0;
                    end else begin
                        r_m_valid <= w_in_fire;
                        if (w_in_fire) begin
                            r_m_data <= w_up_data;
                        end
                    end
                end else if (w_in_fire) begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= w_up_data;
                end
            end

            assign w_up_ready = !r_s_valid;
            assign w_dn_valid = r_m_valid;
            assign w_dn_data  = r_m_data;
        end
    end

    assign axis_sif.tready = g_stage[0].w_up_ready;
    assign axis_mif.tvalid = g_stage[STAGES-1].w_dn_valid;
    assign axis_mif.tdata  = g_stage[STAGES-1].w_dn_data;

    logic               w_sif_fire;
    logic               w_mif_fire;
    logic [c_occ_w-1:0] r_occupancy;

    assign w_sif_fire = axis_sif.tvalid && axis_sif.tready;
    assign w_mif_fire = axis_mif.tvalid && axis_mif.tready;

    always_ff @(posedge clk) begin
        if (rst || invalidate) begin
            r_occupancy <= '0;
        end else if (w_sif_fire && !w_mif_fire) begin
            r_occupancy <= r_occupancy + 1'b1;
        end else if (!w_sif_fire && w_mif_fire) begin
            r_occupancy <= r_occupancy - 1'b1;
        end
    end

    assign occupancy = r_occupancy;
    assign empty     = (r_occupancy == '0);

`ifndef SYNTHESIS
    a_occ_cap: assert property (@(posedge clk) disable iff (rst)
        r_occupancy <= c_occ_w'(c_cap));
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_slice_chain.sv
// ============================================================================
// Module   : tb_axis_slice_chain
// Brief    : Self-checking bench for four axis_slice_chain configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axis_slice_chain;

    // Instance 0: 3 fwd, 1: 2 skid, 2: 2 fwd, 3: 1 fwd
    localparam int c_stages[4] = '{3, 2, 2, 1};
    localparam int c_skid[4]   = '{0, 1, 0, 0};

    logic       clk;
    logic       rst;
    logic       in_valid[4];
    logic [7:0] in_data[4];
    logic       out_ready[4];
    logic       inval[4];
    logic       mif_valid[4];
    logic [7:0] mif_data[4];
    logic       sif_ready[4];
    logic       emp[4];
    int         occ[4];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int c_ow = $clog2(c_stages[g] * (c_skid[g] + 1) + 1);
        logic [c_ow-1:0] w_occ;
        logic            w_empty;

        axis_if #(.TDATA_WIDTH(8)) u_sif ();
        axis_if #(.TDATA_WIDTH(8)) u_mif ();

        assign u_sif.tvalid = in_valid[g];
        assign u_sif.tdata  = in_data[g];
        assign u_mif.tready = out_ready[g];
        assign mif_valid[g] = u_mif.tvalid;
        assign mif_data[g]  = u_mif.tdata;
        assign sif_ready[g] = u_sif.tready;
        assign occ[g]       = int'(w_occ);
        assign emp[g]       = w_empty;

        axis_slice_chain #(.STAGES(c_stages[g]), .SKID(c_skid[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .axis_mif   (u_mif),
            .axis_sif   (u_sif),
            .invalidate (inval[g]),
            .occupancy  (w_occ),
            .empty      (w_empty)
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 8'h00;
            out_ready[i] = 1'b0;
            inval[i]     = 1'b0;
        end
    endtask

    typedef struct {
        int         inst;
        bit         vld;
        logic [7:0] dat;
        bit         rdy;
        bit         ev;
        logic [7:0] ed;
        int         eocc;
        bit         esr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int inst, input bit vld, input logic [7:0] dat,
                       input bit rdy, input bit ev, input logic [7:0] ed,
                       input int eocc, input bit esr);
        vec_t v;
        v.inst = inst; v.vld = vld; v.dat = dat; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.eocc = eocc; v.esr = esr;
        tbl.push_back(v);
    endtask

    // Reference model storage for the random phase: one FIFO per instance.
    logic [7:0] mem[4][4096];
    int         wr[4];
    int         rd[4];
    logic [7:0] nxt[4];
    bit         fired[4];

    initial begin
        logic [7:0] tq[$];
        int         out_cnt;
        bit         done;

        total = 0;
        bad   = 0;
        idle_all();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset%0d tvalid", i), int'(mif_valid[i]), 0);
            chk($sformatf("reset%0d tdata", i), int'(mif_data[i]), 0);
            chk($sformatf("reset%0d occ", i), occ[i], 0);
            chk($sformatf("reset%0d empty", i), int'(emp[i]), 1);
            chk($sformatf("reset%0d sif_ready", i), int'(sif_ready[i]), 1);
        end

        // 3-stage forward chain, downstream always ready
        add(0, 1, 8'h11, 1, 0, 8'h00, 0, 1);
        add(0, 1, 8'h22, 1, 0, 8'h00, 1, 1);
        add(0, 1, 8'h33, 1, 0, 8'h00, 2, 1);
        add(0, 0, 8'h00, 1, 1, 8'h11, 3, 1);
        add(0, 0, 8'h00, 1, 1, 8'h22, 2, 1);
        add(0, 0, 8'h00, 1, 1, 8'h33, 1, 1);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        // 2-stage skid chain: stall fills 4 entries, then drain
        add(1, 1, 8'hA0, 0, 0, 8'h00, 0, 1);
        add(1, 1, 8'hA1, 0, 0, 8'h00, 1, 1);
        add(1, 1, 8'hA2, 0, 1, 8'hA0, 2, 1);
        add(1, 1, 8'hA3, 0, 1, 8'hA0, 3, 1);
        add(1, 1, 8'hA4, 0, 1, 8'hA0, 4, 0);
        add(1, 1, 8'hA4, 0, 1, 8'hA0, 4, 0);
        add(1, 1, 8'hA4, 1, 1, 8'hA0, 4, 0);
        add(1, 1, 8'hA4, 1, 1, 8'hA1, 3, 0);
        add(1, 1, 8'hA4, 1, 1, 8'hA2, 2, 1);
        add(1, 1, 8'hA5, 1, 1, 8'hA3, 2, 1);
        add(1, 0, 8'h00, 1, 1, 8'hA4, 2, 1);
        add(1, 0, 8'h00, 1, 1, 8'hA5, 1, 1);
        add(1, 0, 8'h00, 1, 0, 8'h00, 0, 1);

        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge clk);
            idle_all();
            in_valid[tbl[n].inst]  = tbl[n].vld;
            in_data[tbl[n].inst]   = tbl[n].dat;
            out_ready[tbl[n].inst] = tbl[n].rdy;
            #1;
            chk($sformatf("tbl%0d occ", n), occ[tbl[n].inst], tbl[n].eocc);
            chk($sformatf("tbl%0d empty", n), int'(emp[tbl[n].inst]), int'(tbl[n].eocc == 0));
            chk($sformatf("tbl%0d tvalid", n), int'(mif_valid[tbl[n].inst]), int'(tbl[n].ev));
            chk($sformatf("tbl%0d sif_ready", n), int'(sif_ready[tbl[n].inst]), int'(tbl[n].esr));
            if (tbl[n].ev)
                chk($sformatf("tbl%0d tdata", n), int'(mif_data[tbl[n].inst]), int'(tbl[n].ed));
        end

        // Invalidate on 2-stage forward chain holding two beats
        @(negedge clk); idle_all();
        in_valid[2] = 1'b1; in_data[2] = 8'h01;
        @(negedge clk);
        in_data[2] = 8'h02;
        @(negedge clk);
        in_data[2] = 8'h55; out_ready[2] = 1'b1; inval[2] = 1'b1;
        #1;
        chk("inv held occ", occ[2], 2);
        chk("inv sif_ready", int'(sif_ready[2]), 1);
        @(negedge clk);
        in_valid[2] = 1'b0; inval[2] = 1'b0;
        #1;
        chk("inv occ", occ[2], 0);
        chk("inv empty", int'(emp[2]), 1);
        chk("inv tvalid", int'(mif_valid[2]), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("inv quiet%0d tvalid", k), int'(mif_valid[2]), 0);
        end

        // Single forward slice, downstream ready toggling, continuous input
        idle_all();
        out_cnt = 0;
        nxt[3]  = 8'h40;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid[3]  = 1'b1;
            in_data[3]   = nxt[3];
            out_ready[3] = 1'(k % 2);
            #1;
            if (k >= 1)
                chk($sformatf("tog%0d no bubble", k), int'(mif_valid[3]), 1);
            if (mif_valid[3] && out_ready[3]) begin
                if (tq.size() == 0) begin
                    chk("tog unexpected beat", 1, 0);
                end else begin
                    chk($sformatf("tog%0d tdata", k), int'(mif_data[3]), int'(tq.pop_front()));
                end
                out_cnt++;
            end
            if (in_valid[3] && sif_ready[3]) begin
                tq.push_back(nxt[3]);
                nxt[3] = nxt[3] + 8'd1;
            end
        end
        chk("tog out count", out_cnt, 10);
        @(negedge clk); idle_all();
        for (int i = 0; i < 4; i++) out_ready[i] = 1'b1;
        repeat (4) @(negedge clk);

        // Random valid/ready on all instances against per-instance FIFOs
        idle_all();
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0; rd[i] = 0; nxt[i] = 8'(i * 64); fired[i] = 1'b0;
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] || fired[i]) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    in_data[i]  = nxt[i];
                end
                out_ready[i] = 1'($urandom_range(0, 1));
            end
            #1;
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rnd%0d occ", i), occ[i], wr[i] - rd[i]);
                chk($sformatf("rnd%0d empty", i), int'(emp[i]), int'(wr[i] == rd[i]));
                if (mif_valid[i] && out_ready[i]) begin
                    if (wr[i] == rd[i]) begin
                        chk($sformatf("rnd%0d beat from empty", i), 1, 0);
                    end else begin
                        chk($sformatf("rnd%0d tdata", i), int'(mif_data[i]),
                            int'(mem[i][rd[i][11:0]]));
                        rd[i]++;
                    end
                end
                fired[i] = in_valid[i] && sif_ready[i];
                if (fired[i]) begin
                    mem[i][wr[i][11:0]] = in_data[i];
                    wr[i]++;
                    nxt[i] = nxt[i] + 8'd1;
                end
                if (rd[i] < 1000) done = 1'b0;
            end
        end
        if (!done) chk("rnd timeout beats", rd[1], 1000);

        // Reset with three beats held in the 3-stage forward chain
        @(negedge clk); idle_all();
        for (int i = 0; i < 4; i++) out_ready[i] = 1'b1;
        repeat (8) @(negedge clk);
        idle_all();
        for (int k = 0; k < 3; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'(8'h71 + k);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst held occ", occ[0], 3);
        chk("rst held tvalid", int'(mif_valid[0]), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst tvalid", int'(mif_valid[0]), 0);
        chk("rst tdata", int'(mif_data[0]), 0);
        chk("rst occ", occ[0], 0);
        chk("rst empty", int'(emp[0]), 1);
        chk("rst sif_ready", int'(sif_ready[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
